// File: rtl/mcp_muldiv_pkg.sv
// mcp_muldiv_pkg: shared encodings for the iterative multiply/divide unit.
//   - OP encodings for MULT/MULTU/DIV/DIVU (OP[1] = divide, OP[0] = unsigned)
//   - FSM state encodings
//   - iteration-counter width helper
package mcp_muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  // Counter must hold 0..WL.
  function automatic int cnt_width(input int wl);
    return $clog2(wl + 1);
  endfunction

endpackage

// File: rtl/mcp_signfix.sv
// mcp_signfix: combinational conditional two's-complement negate.
//   neg_i : 1 = negate a_i, 0 = pass through
//   a_i   : W-bit input word
//   y_o   : W-bit result
module mcp_signfix #(
  parameter int W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] a_i,
  output logic [W-1:0] y_o
);

  // Negate as invert-plus-one when requested.
  always_comb begin
    if (neg_i) begin
      y_o = ~a_i + {{(W-1){1'b0}}, 1'b1};
    end else begin
      y_o = a_i;
    end
  end

endmodule

// File: rtl/mcp_muldiv.sv
// mcp_muldiv: iterative MULT/MULTU/DIV/DIVU unit producing a HI/LO pair,
// one bit per clock, with a start/busy/done handshake.
//   CLK, RST_N : rising-edge clock, synchronous active-low reset
//   START, OP  : launch request and operation (sampled only while idle)
//   SrcA, SrcB : multiplicand/dividend, multiplier/divisor
//   HI, LO     : product high/low, or remainder/quotient (registered)
//   BUSY, DONE : operation in progress, one-cycle result-update pulse
//   DIV0_F     : last completed divide had a zero divisor
module mcp_muldiv
  import mcp_muldiv_pkg::*;
#(
  parameter int WL = 32
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic [1:0]    OP,
  input  logic [WL-1:0] SrcA,
  input  logic [WL-1:0] SrcB,
  output logic [WL-1:0] HI,
  output logic [WL-1:0] LO,
  output logic          BUSY,
  output logic          DONE,
  output logic          DIV0_F
);

  localparam int CW = cnt_width(WL);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            is_div_q, div0_q, sign_a_q, sign_b_q;
  logic [WL-1:0]   ma_q, mb_q, rem_q;
  logic [2*WL-1:0] acc_q;
  logic [WL-1:0]   hi_q, lo_q;
  logic            busy_q, done_q, div0f_q;

  // Operand magnitudes; signed ops are those with OP[0] = 0.
  logic            sign_a_s, sign_b_s;
  logic [WL-1:0]   mag_a_s, mag_b_s;
  assign sign_a_s = ~OP[0] & SrcA[WL-1];
  assign sign_b_s = ~OP[0] & SrcB[WL-1];

  mcp_signfix #(.W(WL)) u_mag_a (.neg_i(sign_a_s), .a_i(SrcA), .y_o(mag_a_s));
  mcp_signfix #(.W(WL)) u_mag_b (.neg_i(sign_b_s), .a_i(SrcB), .y_o(mag_b_s));

  // Shift-add step: acc = {product_hi, multiplier_remaining}.
  logic [WL:0]     mul_upper_s;
  logic [2*WL-1:0] mul_next_s;
  assign mul_upper_s = {1'b0, acc_q[2*WL-1:WL]}
                     + (acc_q[0] ? {1'b0, ma_q} : {(WL+1){1'b0}});
  assign mul_next_s  = {mul_upper_s, acc_q[WL-1:1]};

  // Restoring step: dividend bits leave acc_q[WL-1:0] MSB first while
  // quotient bits enter at the LSB.
  logic [WL:0]     div_part_s, div_trial_s;
  logic            div_ok_s;
  assign div_part_s  = {rem_q, acc_q[WL-1]};
  assign div_trial_s = div_part_s - {1'b0, mb_q};
  assign div_ok_s    = ~div_trial_s[WL];

  logic [2*WL-1:0] acc_d;
  logic [WL-1:0]   rem_d;

  // Select the next accumulator/remainder for the operation in flight.
  always_comb begin
    acc_d = acc_q;
    rem_d = rem_q;
    if (is_div_q) begin
      acc_d = {acc_q[2*WL-1:WL], acc_q[WL-2:0], div_ok_s};
      rem_d = div_ok_s ? div_trial_s[WL-1:0] : div_part_s[WL-1:0];
    end else begin
      acc_d = mul_next_s;
    end
  end

  // Sign correction: product/quotient by signA^signB, remainder by signA.
  logic [2*WL-1:0] prod_fix_s;
  logic [WL-1:0]   quo_fix_s, rem_fix_s;
  mcp_signfix #(.W(2*WL)) u_fix_prod (.neg_i(sign_a_q ^ sign_b_q), .a_i(acc_q), .y_o(prod_fix_s));
  mcp_signfix #(.W(WL))   u_fix_quo  (.neg_i(sign_a_q ^ sign_b_q), .a_i(acc_q[WL-1:0]), .y_o(quo_fix_s));
  mcp_signfix #(.W(WL))   u_fix_rem  (.neg_i(sign_a_q), .a_i(rem_q), .y_o(rem_fix_s));

  logic [WL-1:0] hi_d, lo_d;

  // Result words written in FIX.
  always_comb begin
    hi_d = prod_fix_s[2*WL-1:WL];
    lo_d = prod_fix_s[WL-1:0];
    if (div0_q) begin
      hi_d = acc_q[WL-1:0];
      lo_d = {WL{1'b1}};
    end else if (is_div_q) begin
      hi_d = rem_fix_s;
      lo_d = quo_fix_s;
    end else begin
      hi_d = prod_fix_s[2*WL-1:WL];
      lo_d = prod_fix_s[WL-1:0];
    end
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      ma_q     <= {WL{1'b0}};
      mb_q     <= {WL{1'b0}};
      rem_q    <= {WL{1'b0}};
      acc_q    <= {(2*WL){1'b0}};
      hi_q     <= {WL{1'b0}};
      lo_q     <= {WL{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0f_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            busy_q   <= 1'b1;
            div0f_q  <= 1'b0;
            is_div_q <= OP[1];
            sign_a_q <= sign_a_s;
            sign_b_q <= sign_b_s;
            ma_q     <= mag_a_s;
            mb_q     <= mag_b_s;
            rem_q    <= {WL{1'b0}};
            cnt_q    <= {CW{1'b0}};
            if (OP[1] && (SrcB == {WL{1'b0}})) begin
              // Zero divisor skips iteration; raw SrcA becomes HI.
              div0_q  <= 1'b1;
              acc_q   <= {{WL{1'b0}}, SrcA};
              state_q <= S_FIX;
            end else begin
              div0_q  <= 1'b0;
              acc_q   <= {{WL{1'b0}}, (OP[1] ? mag_a_s : mag_b_s)};
              state_q <= S_RUN;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == CW'(WL - 1)) begin
            state_q <= S_FIX;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          div0f_q <= div0_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign HI     = hi_q;
  assign LO     = lo_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign DIV0_F = div0f_q;

endmodule

// File: tb/tb_mcp_muldiv.sv
module tb_mcp_muldiv;
  import mcp_muldiv_pkg::*;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST_N, START, START8;
  logic [1:0]  OP, OP8;
  logic [31:0] SrcA, SrcB, HI, LO;
  logic        BUSY, DONE, DIV0_F;
  logic [7:0]  A8, B8, HI8, LO8;
  logic        BUSY8, DONE8, F8;

  mcp_muldiv #(.WL(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .SrcA(SrcA), .SrcB(SrcB),
    .HI(HI), .LO(LO), .BUSY(BUSY), .DONE(DONE), .DIV0_F(DIV0_F)
  );

  mcp_muldiv #(.WL(8)) dut8 (
    .CLK(CLK), .RST_N(RST_N), .START(START8), .OP(OP8), .SrcA(A8), .SrcB(B8),
    .HI(HI8), .LO(LO8), .BUSY(BUSY8), .DONE(DONE8), .DIV0_F(F8)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        f;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb8_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  // Reference: native 64-bit arithmetic on wl-bit operands.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int wl);
    exp_t        e;
    logic [63:0] mask, up;
    longint      sa, sb, q, r;
    mask = (64'd1 << wl) - 64'd1;
    sa = longint'(a & mask[31:0]);
    sb = longint'(b & mask[31:0]);
    if (!op[0] && a[wl-1]) sa = sa - (longint'(1) << wl);
    if (!op[0] && b[wl-1]) sb = sb - (longint'(1) << wl);
    e.f = 1'b0;
    if (!op[1]) begin
      up   = 64'(sa * sb);
      e.hi = 32'((up >> wl) & mask);
      e.lo = 32'(up & mask);
    end else if (sb == 0) begin
      e.hi = a & mask[31:0];
      e.lo = mask[31:0];
      e.f  = 1'b1;
    end else begin
      q    = sa / sb;
      r    = sa % sb;
      e.hi = 32'(64'(r) & mask);
      e.lo = 32'(64'(q) & mask);
    end
    return e;
  endfunction

  task automatic pulse_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    START = 1'b1; OP = op; SrcA = a; SrcB = b;
    @(negedge CLK);
    START = 1'b0; OP = 2'($urandom); SrcA = $urandom; SrcB = $urandom;
  endtask

  task automatic run_check(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat);
    exp_t e;
    int   n;
    sb_q.push_back(model(op, a, b, 32));
    pulse_start(op, a, b);
    n = 0;
    while (DONE !== 1'b1 && n < 200) begin
      if (n == 5 && exp_lat > 5) begin
        n_cmp++;
        if ({HI, LO} !== {last_hi, last_lo}) begin
          n_bad++;
          $display("FAIL %s hold_during_run: got %h_%h expected %h_%h", name, HI, LO, last_hi, last_lo);
        end
      end
      @(negedge CLK);
      n++;
    end
    e = sb_q.pop_front();
    n_cmp++;
    if (n !== exp_lat) begin
      n_bad++;
      $display("FAIL %s latency: got %0d expected %0d", name, n, exp_lat);
    end
    n_cmp++;
    if ({HI, LO, DIV0_F} !== {e.hi, e.lo, e.f}) begin
      n_bad++;
      $display("FAIL %s result: got HI=%h LO=%h F=%b expected HI=%h LO=%h F=%b",
               name, HI, LO, DIV0_F, e.hi, e.lo, e.f);
    end
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; START = 1'b0; START8 = 1'b0;
    OP = 2'b00; SrcA = 32'd0; SrcB = 32'd0; OP8 = 2'b00; A8 = 8'd0; B8 = 8'd0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({HI, LO, BUSY, DONE, DIV0_F} !== 67'd0) begin
      n_bad++;
      $display("FAIL reset_state: got HI=%h LO=%h B=%b D=%b F=%b expected all 0", HI, LO, BUSY, DONE, DIV0_F);
    end
    RST_N = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    logic seen;
    run_check("div0_before_reset", OP_DIVU, 32'h55, 32'h0, 1);
    pulse_start(OP_MULTU, 32'd100, 32'd200);
    repeat (10) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    n_cmp++;
    if ({HI, LO, BUSY, DONE, DIV0_F} !== 67'd0) begin
      n_bad++;
      $display("FAIL reset_mid_run: got HI=%h LO=%h B=%b D=%b F=%b expected all 0", HI, LO, BUSY, DONE, DIV0_F);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_no_done: got DONE seen=%b expected 0", seen);
    end
    last_hi = 32'd0;
    last_lo = 32'd0;
    run_check("multu_3x5", OP_MULTU, 32'd3, 32'd5, 33);
  endtask

  task automatic test_mult();
    run_check("mult_m2x3", OP_MULT, 32'hFFFFFFFE, 32'h3, 33);
    run_check("multu_m2x3", OP_MULTU, 32'hFFFFFFFE, 32'h3, 33);
  endtask

  task automatic test_div();
    run_check("div_m7d2", OP_DIV, 32'hFFFFFFF9, 32'd2, 33);
    run_check("divu_7d2", OP_DIVU, 32'd7, 32'd2, 33);
    run_check("div_7dm2", OP_DIV, 32'd7, 32'hFFFFFFFE, 33);
  endtask

  task automatic test_div0();
    run_check("divu_by0", OP_DIVU, 32'h1234, 32'h0, 1);
    run_check("div_10d3", OP_DIV, 32'd10, 32'd3, 33);
  endtask

  task automatic test_boundary();
    run_check("div_minneg_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 33);
    run_check("mult_minneg_sq", OP_MULT, 32'h80000000, 32'h80000000, 33);
    run_check("multu_max_sq", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int   n;
    sb_q.push_back(model(OP_MULT, 32'd1234, 32'hFFFFFF00, 32));
    pulse_start(OP_MULT, 32'd1234, 32'hFFFFFF00);
    n = 0;
    while (DONE !== 1'b1 && n < 200) begin
      if ((n % 4) == 1 && n < 30) begin
        START = 1'b1; OP = OP_DIVU; SrcA = $urandom; SrcB = 32'd0;
      end else begin
        START = 1'b0;
      end
      @(negedge CLK);
      n++;
    end
    START = 1'b0;
    e = sb_q.pop_front();
    n_cmp++;
    if (n !== 33) begin
      n_bad++;
      $display("FAIL busy_ignore latency: got %0d expected 33", n);
    end
    n_cmp++;
    if ({HI, LO, DIV0_F} !== {e.hi, e.lo, e.f}) begin
      n_bad++;
      $display("FAIL busy_ignore result: got %h_%h F=%b expected %h_%h F=%b", HI, LO, DIV0_F, e.hi, e.lo, e.f);
    end
    last_hi = e.hi;
    last_lo = e.lo;
    // The unit must be idle again: no stray op launched by the ignored pulses.
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_ignore idle: got BUSY=%b expected 0", BUSY);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   gap;
    run_check("b2b_first", OP_DIVU, 32'd1000, 32'd7, 33);
    sb_q.push_back(model(OP_MULT, 32'hFFFFFFF0, 32'd9, 32));
    START = 1'b1; OP = OP_MULT; SrcA = 32'hFFFFFFF0; SrcB = 32'd9;
    @(negedge CLK);
    START = 1'b0;
    gap = 1;
    while (DONE !== 1'b1 && gap < 200) begin
      @(negedge CLK);
      gap++;
    end
    e = sb_q.pop_front();
    n_cmp++;
    if (gap !== 34) begin
      n_bad++;
      $display("FAIL b2b gap: got %0d expected 34", gap);
    end
    n_cmp++;
    if ({HI, LO, DIV0_F} !== {e.hi, e.lo, e.f}) begin
      n_bad++;
      $display("FAIL b2b second: got %h_%h F=%b expected %h_%h F=%b", HI, LO, DIV0_F, e.hi, e.lo, e.f);
    end
  endtask

  task automatic test_random8();
    exp_t       e;
    int         n, lat;
    logic [1:0] op;
    logic [7:0] a, b;
    for (int i = 0; i < 48; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      b  = ((i % 8) == 3) ? 8'd0 : 8'($urandom);
      if (i == 0) begin op = OP_DIV;  a = 8'h80; b = 8'hFF; end
      if (i == 1) begin op = OP_MULT; a = 8'h80; b = 8'h80; end
      lat = (op[1] && b == 8'd0) ? 1 : 9;
      sb8_q.push_back(model(op, {24'd0, a}, {24'd0, b}, 8));
      @(negedge CLK);
      START8 = 1'b1; OP8 = op; A8 = a; B8 = b;
      @(negedge CLK);
      START8 = 1'b0; A8 = 8'($urandom); B8 = 8'($urandom);
      n = 0;
      while (DONE8 !== 1'b1 && n < 100) begin
        @(negedge CLK);
        n++;
      end
      e = sb8_q.pop_front();
      n_cmp++;
      if ({n == lat, HI8, LO8, F8} !== {1'b1, e.hi[7:0], e.lo[7:0], e.f}) begin
        n_bad++;
        $display("FAIL rand8[%0d] op=%b a=%h b=%h: got HI=%h LO=%h F=%b lat=%0d expected HI=%h LO=%h F=%b lat=%0d",
                 i, op, a, b, HI8, LO8, F8, n, e.hi[7:0], e.lo[7:0], e.f, lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_mult();
    test_div();
    test_div0();
    test_boundary();
    test_busy_ignore();
    test_back_to_back();
    test_random8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mcp_muldiv.md
# mcp_muldiv

Parametrised iterative multiply/divide unit for the MIPS multi-cycle datapath. It implements MULT, MULTU, DIV and DIVU into a HI/LO result pair and sits beside the ALU/adder in the execute stage. A start/busy/done handshake lets the control FSM stall while the unit iterates one bit per clock.

## Interface
- WL, 32: operand word length; HI and LO are each WL bits; WL ≥ 4.
- CLK  input  1  rising-edge clock.
- RST_N  input  1  synchronous, active-low reset.
- START  input  1  launch an operation; sampled only while BUSY=0.
- OP  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- SrcA  input  WL  multiplicand / dividend.
- SrcB  input  WL  multiplier / divisor.
- HI  output  WL  upper product word, or remainder.
- LO  output  WL  lower product word, or quotient.
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle pulse when HI/LO are updated.
- DIV0_F  output  1  last completed divide had divisor 0; held until the next accepted START.

## Operation
- States:
  - IDLE -> RUN on START (operands and OP latched).
  - RUN -> FIX after WL iterations.
  - FIX -> IDLE.
- Divide by zero (OP=1x, SrcB=0):
  - IDLE -> FIX directly.
  - Results: HI=SrcA, LO = all ones, DIV0_F=1.
- Signed ops (MULT, DIV):
  - Latch the magnitudes of SrcA/SrcB and their sign bits.
  - Unsigned ops latch the operands unchanged.
- MULT/MULTU:
  - Shift-add on a 2·WL-bit accumulator, one multiplier bit per RUN cycle, LSB first.
- DIV/DIVU:
  - Restoring division, one quotient bit per RUN cycle, MSB first.
  - WL+1-bit partial remainder.
- FIX applies signs:
  - Product is negated (2·WL-bit two's complement) if signA^signB.
  - Quotient is negated if signA^signB.
  - Remainder takes the sign of the dividend (truncating division, MIPS semantics).
- FIX writes HI/LO and DIV0_F.
- HI/LO hold their value from the last DONE until the next DONE; they are not disturbed during RUN.
- Boundary results:
  - Signed most-negative ÷ -1 gives LO = most-negative (wraps), HI=0, no flag.
  - Most-negative × most-negative gives the exact 2·WL-bit result.
  - No overflow flag exists; every product fits in 2·WL bits.
- START while BUSY=1 is ignored; the operation in flight is unaffected.
- OP, SrcA and SrcB are don't-care after the START cycle.

## Timing
- Reset (RST_N=0 at an edge) forces:
  - state IDLE;
  - HI=0, LO=0;
  - BUSY=0, DONE=0, DIV0_F=0.
- Reset overrides everything, including mid-RUN; the aborted operation produces no DONE.
- START accepted at edge k:
  - BUSY=1 from edge k.
  - RUN iterations occur at edges k+1 … k+WL.
  - FIX at edge k+WL+1 registers HI/LO, sets DONE=1 and BUSY=0.
  - Latency is WL+1 cycles (33 for WL=32).
- Divide by zero: FIX at edge k+1; DONE after edge k+1.
- DONE is high for exactly one cycle.
- A START asserted during that DONE cycle is accepted (back-to-back throughput of WL+2 cycles).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package mcp_muldiv_pkg holds:
  - OP encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state encodings: S_IDLE, S_RUN, S_FIX;
  - an iteration-counter width of $clog2(WL+1).
- One sub-module, mcp_signfix: combinational conditional two's-complement negate, parametrised width.
  - Instantiated for operand magnitude (WL).
  - Instantiated for product/quotient/remainder correction (2·WL and WL).
- FSM, counter, accumulator and remainder datapath live in the top module.

## Test plan
- Reset mid-RUN, then release → all outputs 0, no DONE pulse. Then START MULTU 3×5 → HI=0, LO=15; DONE occurs exactly 33 cycles after START.
- MULT, WL=32: SrcA=0xFFFFFFFE (−2), SrcB=0x00000003 → HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV: −7 ÷ 2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU 7 ÷ 2 → LO=3, HI=1.
- DIVU 0x1234 ÷ 0 → DONE after 1 cycle, DIV0_F=1, HI=0x1234, LO=0xFFFFFFFF. The next DIV 10 ÷ 3 clears DIV0_F: LO=3, HI=1.
- DIV 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0, DIV0_F=0. MULT 0x80000000×0x80000000 → HI=0x40000000, LO=0.
- START pulsed repeatedly while BUSY → ignored and result unchanged. START in the DONE cycle → accepted, with the second DONE exactly 34 cycles after the first. Random-operand sweep at WL=8 checked against a reference model.
